// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 execution stage.
package td4_pkg;

  typedef logic [3:0] word_t;

  // The twelve defined TD4 opcodes (rom_data[7:4]).
  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } op_e;

  // Data-selector codes as {sel_b, sel_a}.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Width of the free-run prescaler; holds DIV-1 for DIV up to 2^24.
  localparam int unsigned STEP_CNT_W = 24;

endpackage

// File: rtl/td4_exec_if.sv
// Bus between the TD4 execution stage and its surroundings:
// ROM, data selector, switches, LEDs and step controls.
interface td4_exec_if;
  import td4_pkg::*;

  logic [7:0] rom_data;
  word_t      in_port;
  word_t      sel_y;
  logic       step_mode;
  logic       step_req;
  logic       sel_a;
  logic       sel_b;
  word_t      reg_a;
  word_t      reg_b;
  word_t      out_port;
  word_t      pc;
  logic       carry;
  logic       step;

  // Environment side: ROM, selector, switches and step controls.
  modport master (
    output rom_data, in_port, sel_y, step_mode, step_req,
    input  sel_a, sel_b, reg_a, reg_b, out_port, pc, carry, step
  );

  // Execution-stage side.
  modport slave (
    input  rom_data, in_port, sel_y, step_mode, step_req,
    output sel_a, sel_b, reg_a, reg_b, out_port, pc, carry, step
  );

endinterface

// File: rtl/td4_step_gen.sv
// Step pulse generator: free-running prescaler or debounced-by-sync
// manual single step. Produces a registered one-cycle step pulse.
module td4_step_gen
  import td4_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic step_mode,
  input  logic step_req,
  output logic step
);

  localparam logic [STEP_CNT_W-1:0] DIV_LAST = STEP_CNT_W'(DIV - 1);

  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;
  logic mode_q, mode_d;
  logic step_q, step_d;

  // Next-state: prescaler in free-run, edge detect in manual, clear on mode change.
  always_comb begin
    cnt_d   = cnt_q;
    sync1_d = step_req;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    mode_d  = step_mode;
    step_d  = 1'b0;
    if (step_mode != mode_q) begin
      // Mode just changed: drop all history so no stale step leaks through.
      cnt_d   = '0;
      sync1_d = 1'b0;
      sync2_d = 1'b0;
      hist_d  = 1'b0;
    end else if (!step_mode) begin
      sync1_d = 1'b0;
      sync2_d = 1'b0;
      hist_d  = 1'b0;
      if (cnt_q == DIV_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d  = '0;
      step_d = sync2_q & ~hist_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      mode_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/td4_exec.sv
// TD4 execution stage: decodes the ROM byte, drives the data selector,
// adds the immediate and commits A, B, OUT, PC and carry on each step.
module td4_exec
  import td4_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  td4_exec_if.slave     bus
);

  word_t a_q, a_d;
  word_t b_q, b_d;
  word_t out_q, out_d;
  word_t pc_q, pc_d;
  logic  carry_q, carry_d;

  logic       step;
  logic [3:0] op;
  word_t      imm;
  logic [4:0] sum_full;
  word_t      sum;
  logic       co;
  logic       ld_a, ld_b, ld_out, ld_pc;

  td4_step_gen #(.DIV(DIV)) u_step_gen (
    .clk       (clk),
    .rst       (rst),
    .step_mode (bus.step_mode),
    .step_req  (bus.step_req),
    .step      (step)
  );

  assign op  = bus.rom_data[7:4];
  assign imm = bus.rom_data[3:0];

  // Selector source: c0=A, c1=B, c2=in_port, c3=0.
  assign bus.sel_a = bus.rom_data[4] | bus.rom_data[7];
  assign bus.sel_b = bus.rom_data[5];

  assign sum_full = {1'b0, bus.sel_y} + {1'b0, imm};
  assign sum      = sum_full[3:0];
  assign co       = sum_full[4];

  // Decode load enables; undefined opcodes enable nothing.
  always_comb begin
    ld_a   = (op[3:2] == 2'b00);
    ld_b   = (op[3:2] == 2'b01);
    ld_out = (op == OP_OUT_B) || (op == OP_OUT_I);
    ld_pc  = (op == OP_JMP) || ((op == OP_JNC) && !carry_q);
  end

  // Next architectural state, committed only in a step cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    if (step) begin
      if (ld_a)   a_d   = sum;
      if (ld_b)   b_d   = sum;
      if (ld_out) out_d = sum;
      pc_d    = ld_pc ? sum : pc_q + 1'b1;
      carry_d = co;
    end
  end

  // Architectural registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
    end
  end

  assign bus.reg_a    = a_q;
  assign bus.reg_b    = b_q;
  assign bus.out_port = out_q;
  assign bus.pc       = pc_q;
  assign bus.carry    = carry_q;
  assign bus.step     = step;

endmodule
